// File: rtl/noc_pkg.sv
// Shared definitions for the NoC switch: port index map, destination index
// width and the per-output allocation states.
package noc_pkg;

   localparam int PORT_L = 0;
   localparam int PORT_N = 1;
   localparam int PORT_E = 2;
   localparam int PORT_S = 3;
   localparam int PORT_W = 4;

   localparam int SEL_W = 3;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

endpackage

// File: rtl/noc_xbar_switch_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer,
// wrapping, and advances the pointer past the winner when strobed.
module rr_arbiter #(
   parameter int N  = 5,
   parameter int IW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          en,
   input  logic          upd,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   logic [IW-1:0] ptr;
   logic          found;

   // Two passes: requests at/after the pointer first, then the wrapped ones.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      if (en) begin
         for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j >= int'(ptr))) begin
               gnt[j]  = 1'b1;
               gnt_idx = IW'(j);
               found   = 1'b1;
            end
         end
         for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j < int'(ptr))) begin
               gnt[j]  = 1'b1;
               gnt_idx = IW'(j);
               found   = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (upd && found) begin
         ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
      end
   end

endmodule

// File: rtl/noc_xbar_switch.sv
// N-port registered crossbar with per-output round-robin allocation,
// wormhole locking until the tail flit, and discard of out-of-range heads.
module noc_xbar_switch #(
   parameter int NUM_PORTS  = 5,
   parameter int DATA_WIDTH = 128,
   parameter int SEL_W      = noc_pkg::SEL_W
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PORTS-1:0]            in_valid,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_PORTS*SEL_W-1:0]      in_dest,
   input  logic [NUM_PORTS-1:0]            in_last,
   output logic [NUM_PORTS-1:0]            in_ready,
   output logic [NUM_PORTS-1:0]            out_valid,
   output logic [NUM_PORTS*DATA_WIDTH-1:0] out_data,
   output logic [NUM_PORTS-1:0]            out_last,
   output logic [NUM_PORTS*SEL_W-1:0]      out_src,
   input  logic [NUM_PORTS-1:0]            out_ready,
   output logic [NUM_PORTS-1:0]            drop_pulse
);
   import noc_pkg::*;

   state_e                  state_q [NUM_PORTS];
   state_e                  state_d [NUM_PORTS];
   logic [SEL_W-1:0]        lock_q  [NUM_PORTS];
   logic [SEL_W-1:0]        lock_d  [NUM_PORTS];
   logic [NUM_PORTS-1:0]    drop_q, drop_d;

   logic [SEL_W-1:0]        dest    [NUM_PORTS];
   logic [NUM_PORTS-1:0]    locked_any, free, head_drop, can_acc, arb_en;
   logic [NUM_PORTS-1:0]    req     [NUM_PORTS];
   logic [NUM_PORTS-1:0]    gnt     [NUM_PORTS];
   logic [SEL_W-1:0]        gidx    [NUM_PORTS];
   logic [NUM_PORTS-1:0]    xfer, sel_last, in_rdy;
   logic [SEL_W-1:0]        src     [NUM_PORTS];
   logic [DATA_WIDTH-1:0]   sel_data[NUM_PORTS];

   logic [NUM_PORTS-1:0]    vld_p1, last_p1;
   logic [DATA_WIDTH-1:0]   data_p1 [NUM_PORTS];
   logic [SEL_W-1:0]        src_p1  [NUM_PORTS];

   // An input is a head candidate only when no output holds it and it is not
   // inside a packet being discarded.
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         dest[i]       = in_dest[i*SEL_W +: SEL_W];
         locked_any[i] = 1'b0;
         for (int o = 0; o < NUM_PORTS; o++) begin
            if (state_q[o] == ST_LOCKED && lock_q[o] == SEL_W'(i)) locked_any[i] = 1'b1;
         end
         free[i]      = in_valid[i] && !locked_any[i] && !drop_q[i];
         head_drop[i] = free[i] && (int'(dest[i]) >= NUM_PORTS);
      end
      for (int o = 0; o < NUM_PORTS; o++) begin
         can_acc[o] = !vld_p1[o] || out_ready[o];
         arb_en[o]  = (state_q[o] == ST_IDLE) && can_acc[o];
         req[o]     = '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            req[o][i] = free[i] && (dest[i] == SEL_W'(o));
         end
      end
   end

   for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
      rr_arbiter #(.N(NUM_PORTS), .IW(SEL_W)) u_arb (
         .clk     (clk),
         .rst     (rst),
         .req     (req[o]),
         .en      (arb_en[o]),
         .upd     (arb_en[o]),
         .gnt     (gnt[o]),
         .gnt_idx (gidx[o])
      );
      assign out_data[o*DATA_WIDTH +: DATA_WIDTH] = data_p1[o];
      assign out_src[o*SEL_W +: SEL_W]            = src_p1[o];
   end

   // Crossbar: per output pick the granted or locked input, then reflect
   // accepted transfers back as in_ready.
   always_comb begin
      in_rdy = (drop_q & in_valid) | head_drop;
      for (int o = 0; o < NUM_PORTS; o++) begin
         if (state_q[o] == ST_IDLE) begin
            xfer[o] = |gnt[o];
            src[o]  = gidx[o];
         end else begin
            xfer[o] = 1'b0;
            src[o]  = lock_q[o];
            for (int i = 0; i < NUM_PORTS; i++) begin
               if (lock_q[o] == SEL_W'(i)) xfer[o] = in_valid[i] && can_acc[o];
            end
         end
         sel_data[o] = '0;
         sel_last[o] = 1'b0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (src[o] == SEL_W'(i)) begin
               sel_data[o] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
               sel_last[o] = in_last[i];
               if (xfer[o]) in_rdy[i] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      for (int o = 0; o < NUM_PORTS; o++) begin
         state_d[o] = state_q[o];
         lock_d[o]  = lock_q[o];
         if (xfer[o]) begin
            case (state_q[o])
               ST_IDLE: begin
                  if (!sel_last[o]) begin
                     state_d[o] = ST_LOCKED;
                     lock_d[o]  = src[o];
                  end
               end
               ST_LOCKED: if (sel_last[o]) state_d[o] = ST_IDLE;
               default:   state_d[o] = ST_IDLE;
            endcase
         end
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
         drop_d[i] = drop_q[i];
         if (head_drop[i] && !in_last[i]) drop_d[i] = 1'b1;
         else if (drop_q[i] && in_valid[i] && in_last[i]) drop_d[i] = 1'b0;
      end
   end

   // Stage p1: allocation state and the one-flit output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_q  <= '0;
         vld_p1  <= '0;
         last_p1 <= '0;
         for (int o = 0; o < NUM_PORTS; o++) begin
            state_q[o] <= ST_IDLE;
            lock_q[o]  <= '0;
            data_p1[o] <= '0;
            src_p1[o]  <= '0;
         end
      end else begin
         drop_q <= drop_d;
         for (int o = 0; o < NUM_PORTS; o++) begin
            state_q[o] <= state_d[o];
            lock_q[o]  <= lock_d[o];
            if (can_acc[o]) begin
               vld_p1[o] <= xfer[o];
               if (xfer[o]) begin
                  data_p1[o] <= sel_data[o];
                  last_p1[o] <= sel_last[o];
                  src_p1[o]  <= src[o];
               end
            end
         end
      end
   end

   assign in_ready   = in_rdy;
   assign out_valid  = vld_p1;
   assign out_last   = last_p1;
   assign drop_pulse = head_drop & {NUM_PORTS{~rst}};

endmodule

// File: tb/tb_noc_xbar_switch.sv
// Bench for noc_xbar_switch: directed scenarios followed by randomized
// packet traffic, all checked against a packet-level reference model.
module tb_noc_xbar_switch;
   import noc_pkg::*;

   localparam int N  = 5;
   localparam int DW = 16;
   localparam int SW = 3;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [SW-1:0] dest;
      logic          last;
   } flit_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    in_valid = '0, in_last = '0, in_ready, out_valid, out_last, out_ready = '1, drop_pulse;
   logic [N*DW-1:0] in_data = '0, out_data;
   logic [N*SW-1:0] in_dest = '0, out_src;

   noc_xbar_switch #(.NUM_PORTS(N), .DATA_WIDTH(DW), .SEL_W(SW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_dest(in_dest),
      .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_last(out_last), .out_src(out_src), .out_ready(out_ready), .drop_pulse(drop_pulse));

   always #5 clk = ~clk;

   int n_assert = 0, n_fail = 0;

   // Sources: per-input flit queues, presented in order until accepted.
   flit_t q [N][$];
   bit    en [N];

   // Reference model: owner of each output (-1 = free), round-robin pointer,
   // discard state per input and the contents of each output slot.
   int            owner [N];
   int            ptr   [N];
   bit            dropping [N];
   bit            sv [N];
   logic [DW-1:0] sd [N];
   bit            sl [N];
   int            ss [N];
   int            serve [N];
   bit            accept [N];
   logic [N-1:0]  exp_ready, exp_drop;

   task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int o = 0; o < N; o++) begin
         owner[o] = -1; ptr[o] = 0; dropping[o] = 0;
         sv[o] = 0; sd[o] = '0; sl[o] = 0; ss[o] = 0;
      end
   endtask

   task automatic model_eval();
      bit busy [N];
      for (int i = 0; i < N; i++) busy[i] = 0;
      for (int o = 0; o < N; o++) if (owner[o] >= 0) busy[owner[o]] = 1;
      exp_ready = '0;
      exp_drop  = '0;
      for (int i = 0; i < N; i++) begin
         if (in_valid[i] && dropping[i]) exp_ready[i] = 1'b1;
         else if (in_valid[i] && !busy[i] && int'(in_dest[i*SW +: SW]) >= N) begin
            exp_ready[i] = 1'b1;
            exp_drop[i]  = 1'b1;
         end
      end
      for (int o = 0; o < N; o++) begin
         accept[o] = !sv[o] || out_ready[o];
         serve[o]  = -1;
         if (accept[o]) begin
            if (owner[o] >= 0) begin
               if (in_valid[owner[o]]) serve[o] = owner[o];
            end else begin
               for (int k = 0; k < N; k++) begin
                  int i;
                  i = (ptr[o] + k) % N;
                  if (serve[o] < 0 && in_valid[i] && !busy[i] && !dropping[i] &&
                      int'(in_dest[i*SW +: SW]) == o) serve[o] = i;
               end
            end
         end
         if (serve[o] >= 0) exp_ready[serve[o]] = 1'b1;
      end
   endtask

   task automatic model_commit();
      for (int o = 0; o < N; o++) begin
         if (accept[o]) begin
            if (serve[o] >= 0) begin
               int s;
               s = serve[o];
               sv[o] = 1; sd[o] = in_data[s*DW +: DW]; sl[o] = in_last[s]; ss[o] = s;
               if (owner[o] < 0) begin
                  ptr[o] = (s + 1) % N;
                  if (!in_last[s]) owner[o] = s;
               end else if (in_last[s]) owner[o] = -1;
            end else sv[o] = 0;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (exp_drop[i] && !in_last[i]) dropping[i] = 1;
         else if (dropping[i] && in_valid[i] && in_last[i]) dropping[i] = 0;
         if (in_valid[i] && exp_ready[i]) void'(q[i].pop_front());
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (q[i].size() > 0 && en[i]) begin
            in_valid[i] = 1'b1;
            in_data[i*DW +: DW] = q[i][0].d;
            in_dest[i*SW +: SW] = q[i][0].dest;
            in_last[i] = q[i][0].last;
         end else begin
            in_valid[i] = 1'b0;
            in_data[i*DW +: DW] = DW'($urandom);
            in_dest[i*SW +: SW] = SW'($urandom);
            in_last[i] = 1'($urandom);
         end
      end
   endtask

   task automatic step_pre();
      drive();
      #1;
      model_eval();
      chk("in_ready", in_ready, exp_ready);
      chk("drop_pulse", drop_pulse, exp_drop);
   endtask

   task automatic step_post();
      @(posedge clk);
      model_commit();
      #1;
      for (int o = 0; o < N; o++) begin
         chk($sformatf("out_valid[%0d]", o), out_valid[o], sv[o]);
         if (sv[o]) begin
            chk($sformatf("out_data[%0d]", o), out_data[o*DW +: DW], sd[o]);
            chk($sformatf("out_last[%0d]", o), out_last[o], sl[o]);
            chk($sformatf("out_src[%0d]", o), out_src[o*SW +: SW], ss[o]);
         end
      end
   endtask

   task automatic step();
      step_pre();
      step_post();
   endtask

   task automatic push(int i, logic [DW-1:0] d, int dest, bit last);
      flit_t f;
      f.d = d; f.dest = SW'(dest); f.last = last;
      q[i].push_back(f);
   endtask

   initial begin
      int exp_rr [6] = '{0, 1, 3, 0, 1, 3};
      logic [DW-1:0] exp_wh [4] = '{16'h001A, 16'h001B, 16'h001C, 16'h004D};
      for (int i = 0; i < N; i++) en[i] = 1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", out_valid, 0);
      chk("reset out_data", out_data, 0);
      chk("reset out_last", out_last, 0);
      chk("reset out_src", out_src, 0);
      chk("reset drop_pulse", drop_pulse, 0);
      rst = 1'b0;

      // Single-flit packet E -> W.
      push(PORT_E, 16'h00A5, PORT_W, 1);
      step_pre();
      chk("single in_ready[2]", in_ready[PORT_E], 1);
      step_post();
      chk("single out_valid[4]", out_valid[PORT_W], 1);
      chk("single out_data[4]", out_data[PORT_W*DW +: DW], 16'h00A5);
      chk("single out_src[4]", out_src[PORT_W*SW +: SW], PORT_E);

      // Round robin among inputs 0, 1, 3 towards output 2.
      for (int r = 0; r < 2; r++) begin
         push(0, 16'h0100 + 16'(r), 2, 1);
         push(1, 16'h0110 + 16'(r), 2, 1);
         push(3, 16'h0130 + 16'(r), 2, 1);
      end
      for (int k = 0; k < 6; k++) begin
         step();
         chk($sformatf("rr valid #%0d", k), out_valid[2], 1);
         chk($sformatf("rr src #%0d", k), out_src[2*SW +: SW], exp_rr[k]);
      end

      // Wormhole: 3-flit packet from input 1 holds output 0 against input 4.
      push(1, 16'h001A, 0, 0);
      push(1, 16'h001B, 7, 0);
      push(1, 16'h001C, 3, 1);
      push(4, 16'h004D, 0, 1);
      for (int k = 0; k < 4; k++) begin
         step_pre();
         chk($sformatf("wh in_ready[4] #%0d", k), in_ready[4], (k == 3));
         step_post();
         chk($sformatf("wh out_data[0] #%0d", k), out_data[0 +: DW], exp_wh[k]);
      end

      // Back-pressure on output 3.
      push(2, 16'h0031, 3, 1);
      push(2, 16'h0032, 3, 1);
      push(2, 16'h0033, 3, 1);
      step();
      out_ready[3] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step_pre();
         chk($sformatf("bp in_ready[2] #%0d", k), in_ready[2], 0);
         step_post();
         chk($sformatf("bp out_data[3] #%0d", k), out_data[3*DW +: DW], 16'h0031);
      end
      out_ready[3] = 1'b1;
      step();
      chk("bp resume #1", out_data[3*DW +: DW], 16'h0032);
      step();
      chk("bp resume #2", out_data[3*DW +: DW], 16'h0033);
      step();

      // Parallel outputs, then an out-of-range head.
      push(0, 16'h0111, 1, 1);
      push(2, 16'h0233, 3, 1);
      step();
      chk("par out_valid[1]", out_valid[1], 1);
      chk("par out_valid[3]", out_valid[3], 1);
      push(3, 16'h0366, 6, 1);
      step_pre();
      chk("drop pulse", drop_pulse[3], 1);
      chk("drop in_ready", in_ready[3], 1);
      step_post();
      chk("drop no output", out_valid, 0);
      step_pre();
      chk("drop pulse gone", drop_pulse, 0);
      step_post();

      // Reset while output 2 is locked to input 0.
      push(0, 16'h0A01, 2, 0);
      push(0, 16'h0A02, 2, 0);
      push(0, 16'h0A03, 2, 1);
      step();
      rst = 1'b1;
      #1;
      chk("rst mid out_valid", out_valid, 0);
      for (int i = 0; i < N; i++) q[i].delete();
      in_valid = '0;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      push(1, 16'h0B01, 2, 1);
      step();
      chk("post-rst valid[2]", out_valid[2], 1);
      chk("post-rst src[2]", out_src[2*SW +: SW], 1);

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
               int len, dest;
               len  = $urandom_range(1, 4);
               dest = ($urandom_range(0, 9) == 0) ? $urandom_range(N, 7) : $urandom_range(0, N - 1);
               for (int f = 0; f < len; f++)
                  push(i, DW'($urandom), (f == 0) ? dest : $urandom_range(0, 7), f == len - 1);
            end
            en[i] = ($urandom_range(0, 4) != 0);
            out_ready[i] = ($urandom_range(0, 3) != 0);
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
